// File: rtl/toy_fetch_pkg.sv
// Shared types for the fetch front-end: response slot layout, slot index
// width for the default credit depth, and the issue FSM encoding.
package toy_fetch_pkg;

  localparam int DEF_MAX_OUTSTANDING = 2;
  localparam int SLOT_IDX_W          = $clog2(DEF_MAX_OUTSTANDING);

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
    logic        filled;
  } fetch_slot_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/toy_fetch_slot_buf.sv
// Response slot ring: slots are allocated in issue order, filled in response
// order and freed in push order; flush drops every slot and rewinds pointers.
module toy_fetch_slot_buf
  import toy_fetch_pkg::*;
#(
  parameter int N     = DEF_MAX_OUTSTANDING,
  parameter int IDX_W = SLOT_IDX_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           alloc,
  input  logic           alloc_mis,
  input  logic           fill,
  input  logic [31:0]    fill_data,
  input  logic           free,
  output logic           rd_filled,
  output logic [31:0]    rd_data,
  output logic           rd_mis,
  output logic [IDX_W:0] alloc_cnt,
  output logic [IDX_W:0] unfilled_cnt
);

  fetch_slot_t      slots [N];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] fill_ptr;
  logic [IDX_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < N; i++) slots[i].filled <= 1'b0;
      wr_ptr       <= '0;
      fill_ptr     <= '0;
      rd_ptr       <= '0;
      alloc_cnt    <= '0;
      unfilled_cnt <= '0;
    end else begin
      if (alloc) begin
        slots[wr_ptr].mis    <= alloc_mis;
        slots[wr_ptr].filled <= 1'b0;
        wr_ptr               <= wr_ptr + IDX_W'(1);
      end
      // fill and free never target the same slot: free needs it already filled
      if (fill) begin
        slots[fill_ptr].data   <= fill_data;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr               <= fill_ptr + IDX_W'(1);
      end
      if (free) begin
        slots[rd_ptr].filled <= 1'b0;
        rd_ptr               <= rd_ptr + IDX_W'(1);
      end
      alloc_cnt    <= alloc_cnt + (IDX_W+1)'(alloc) - (IDX_W+1)'(free);
      unfilled_cnt <= unfilled_cnt + (IDX_W+1)'(alloc) - (IDX_W+1)'(fill);
    end
  end

  assign rd_filled = slots[rd_ptr].filled;
  assign rd_data   = slots[rd_ptr].data;
  assign rd_mis    = slots[rd_ptr].mis;

endmodule

// File: rtl/toy_fetch_unit.sv
// Fetch front-end: issues word-aligned reads from the PC and pushes returned
// words into the fetch queue; redirects flush and squash in-flight responses.
module toy_fetch_unit
  import toy_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0,
  parameter int                    MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_vld,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_vld,
  input  logic                  mem_req_rdy,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_vld,
  input  logic [31:0]           mem_rsp_data,
  output logic                  fq_clear,
  output logic                  fq_req_vld,
  input  logic                  fq_req_rdy,
  output logic [31:0]           fq_req_pld,
  output logic                  fq_mis_align
);

  // state | meaning
  // IDLE  | fetch_en low: no new requests, outstanding responses still drain
  // RUN   | fetch_en high: requests issue while credits remain
  localparam int IDX_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = IDX_W + 1;

  fetch_state_e          state, state_d;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  first_flag;
  logic [CNT_W-1:0]      kill_cnt;
  logic [CNT_W-1:0]      alloc_cnt;
  logic [CNT_W-1:0]      unfilled_cnt;
  logic                  credit_ok;
  logic                  issue_hs;
  logic                  rsp_fill;
  logic                  rsp_kill;
  logic                  push;
  logic                  rd_filled;
  logic [31:0]           rd_data;
  logic                  rd_mis;
  logic                  unused_ok;

  assign credit_ok = ({1'b0, alloc_cnt} + {1'b0, kill_cnt}) < (CNT_W+1)'(MAX_OUTSTANDING);

  always_comb begin
    state_d     = state;
    mem_req_vld = 1'b0;
    case (state)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    mem_req_vld = ~rst & fetch_en & ~redirect_vld & credit_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  assign mem_req_addr = {pc[ADDR_WIDTH-1:2], 2'b00};
  assign issue_hs     = mem_req_vld & mem_req_rdy;
  assign rsp_kill     = mem_rsp_vld & (kill_cnt != '0);
  assign rsp_fill     = mem_rsp_vld & (kill_cnt == '0) & (unfilled_cnt != '0) & ~redirect_vld;

  assign fq_clear     = ~rst & redirect_vld;
  assign fq_req_vld   = ~rst & ~redirect_vld & rd_filled;
  assign fq_req_pld   = fq_req_vld ? rd_data : 32'h0;
  assign fq_mis_align = fq_req_vld & rd_mis;
  assign push         = fq_req_vld & fq_req_rdy;

  assign unused_ok    = ^{redirect_pc[0], pc[1:0]};

  toy_fetch_slot_buf #(
    .N     (MAX_OUTSTANDING),
    .IDX_W (IDX_W)
  ) u_slot_buf (
    .clk          (clk),
    .rst          (rst),
    .flush        (redirect_vld),
    .alloc        (issue_hs),
    .alloc_mis    (first_flag),
    .fill         (rsp_fill),
    .fill_data    (mem_rsp_data),
    .free         (push),
    .rd_filled    (rd_filled),
    .rd_data      (rd_data),
    .rd_mis       (rd_mis),
    .alloc_cnt    (alloc_cnt),
    .unfilled_cnt (unfilled_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      first_flag <= RESET_PC[1];
      kill_cnt   <= '0;
    end else if (redirect_vld) begin
      pc         <= {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      first_flag <= redirect_pc[1];
      // a response landing now retires either a pending kill or one in-flight request
      kill_cnt   <= kill_cnt + unfilled_cnt - CNT_W'(mem_rsp_vld);
    end else begin
      if (issue_hs) begin
        pc         <= {pc[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'(4);
        first_flag <= 1'b0;
      end
      if (rsp_kill) kill_cnt <= kill_cnt - CNT_W'(1);
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    mem_rsp_vld |-> ((kill_cnt != '0) || (unfilled_cnt != '0)));

  assert property (@(posedge clk) disable iff (rst)
    ({1'b0, alloc_cnt} + {1'b0, kill_cnt}) <= (CNT_W+1)'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_toy_fetch_unit.sv
// Directed bench for toy_fetch_unit with an in-order, 1-cycle memory model
// whose responses can be held back to build up requests in flight.
module tb_toy_fetch_unit;

  logic        clk          = 1'b0;
  logic        rst          = 1'b1;
  logic        fetch_en     = 1'b0;
  logic        redirect_vld = 1'b0;
  logic [31:0] redirect_pc  = 32'h0;
  logic        mem_req_rdy  = 1'b1;
  logic        mem_rsp_vld  = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        fq_req_rdy   = 1'b1;
  logic        mem_req_vld;
  logic [31:0] mem_req_addr;
  logic        fq_clear;
  logic        fq_req_vld;
  logic [31:0] fq_req_pld;
  logic        fq_mis_align;

  int n_cmp = 0;
  int n_err = 0;

  logic        rsp_hold = 1'b0;
  int          cyc = 0;
  int          unans = 0;
  int          max_unans = 0;
  int          n_clear = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] issued[$];
  logic [32:0] pushed[$];

  toy_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .mem_req_vld  (mem_req_vld),
    .mem_req_rdy  (mem_req_rdy),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_vld  (mem_rsp_vld),
    .mem_rsp_data (mem_rsp_data),
    .fq_clear     (fq_clear),
    .fq_req_vld   (fq_req_vld),
    .fq_req_rdy   (fq_req_rdy),
    .fq_req_pld   (fq_req_pld),
    .fq_mis_align (fq_mis_align)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Observe handshakes, pushes and clears away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      unans = 0;
    end else begin
      if (mem_req_vld && mem_req_rdy) begin
        issued.push_back(mem_req_addr);
        q_addr.push_back(mem_req_addr);
        q_due.push_back(cyc + 1);
        unans = unans + 1;
      end
      if (mem_rsp_vld) unans = unans - 1;
      if (unans > max_unans) max_unans = unans;
      if (fq_req_vld && fq_req_rdy) pushed.push_back({fq_mis_align, fq_req_pld});
      if (fq_clear) n_clear = n_clear + 1;
    end
  end

  // In-order memory: answers each request the cycle after its handshake.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (!rsp_hold && q_addr.size() > 0 && q_due[0] <= cyc) begin
      mem_rsp_vld  = 1'b1;
      mem_rsp_data = word_of(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      mem_rsp_vld  = 1'b0;
      mem_rsp_data = 32'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    fetch_en    = 1'b0;
    mem_req_rdy = 1'b1;
    fq_req_rdy  = 1'b1;
    rsp_hold    = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    fetch_en = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if (mem_req_vld !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_vld: got %b expected 0", mem_req_vld); end
    n_cmp++;
    if (fq_req_vld !== 1'b0) begin n_err++; $display("FAIL reset_fq_req_vld: got %b expected 0", fq_req_vld); end
    n_cmp++;
    if (fq_clear !== 1'b0) begin n_err++; $display("FAIL reset_fq_clear: got %b expected 0", fq_clear); end
    n_cmp++;
    if (mem_req_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 00000000", mem_req_addr); end
  endtask

  task automatic test_seq_stream();
    logic [32:0] got;
    tick();
    rst = 1'b0;
    issued.delete();
    pushed.delete();
    max_unans = 0;
    repeat (20) tick();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (((issued.size() > i) ? issued[i] : 32'hx) !== 32'(4 * i)) begin
        n_err++;
        $display("FAIL seq_addr[%0d]: got %h expected %h", i, (issued.size() > i) ? issued[i] : 32'hx, 32'(4 * i));
      end
      got = (pushed.size() > i) ? pushed[i] : {33{1'bx}};
      n_cmp++;
      if (got !== {1'b0, word_of(32'(4 * i))}) begin
        n_err++;
        $display("FAIL seq_word[%0d]: got %h expected %h", i, got, {1'b0, word_of(32'(4 * i))});
      end
    end
    n_cmp++;
    if (max_unans > 2) begin n_err++; $display("FAIL seq_unanswered: got %0d expected at most 2", max_unans); end
    drain();
  endtask

  task automatic test_redirect_misalign();
    logic [32:0] got;
    issued.delete();
    pushed.delete();
    n_clear = 0;
    tick();
    redirect_vld = 1'b1;
    redirect_pc  = 32'h0000_0102;
    fetch_en     = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({fq_clear, mem_req_vld} !== 2'b10) begin n_err++; $display("FAIL redir_cycle clear/req: got %b expected 10", {fq_clear, mem_req_vld}); end
    tick();
    redirect_vld = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({fq_clear, mem_req_vld, mem_req_addr} !== {2'b01, 32'h0000_0100}) begin
      n_err++;
      $display("FAIL redir_next clear/req/addr: got %b %b %h expected 0 1 00000100", fq_clear, mem_req_vld, mem_req_addr);
    end
    repeat (10) tick();
    @(negedge clk);
    n_cmp++;
    if (n_clear !== 1) begin n_err++; $display("FAIL redir_clear_cycles: got %0d expected 1", n_clear); end
    got = (pushed.size() > 0) ? pushed[0] : {33{1'bx}};
    n_cmp++;
    if (got !== {1'b1, word_of(32'h100)}) begin n_err++; $display("FAIL redir_first_word: got %h expected %h", got, {1'b1, word_of(32'h100)}); end
    got = (pushed.size() > 1) ? pushed[1] : {33{1'bx}};
    n_cmp++;
    if (got !== {1'b0, word_of(32'h104)}) begin n_err++; $display("FAIL redir_second_word: got %h expected %h", got, {1'b0, word_of(32'h104)}); end
    n_cmp++;
    if (((issued.size() > 1) ? issued[1] : 32'hx) !== 32'h104) begin
      n_err++;
      $display("FAIL redir_second_addr: got %h expected 00000104", (issued.size() > 1) ? issued[1] : 32'hx);
    end
    drain();
  endtask

  task automatic test_fq_backpressure();
    logic [32:0] got;
    issued.delete();
    pushed.delete();
    tick();
    redirect_vld = 1'b1;
    redirect_pc  = 32'h0000_0200;
    fetch_en     = 1'b1;
    fq_req_rdy   = 1'b0;
    tick();
    redirect_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        n_cmp++;
        if (mem_req_vld !== 1'b0) begin n_err++; $display("FAIL bp_full_req_vld[%0d]: got %b expected 0", i, mem_req_vld); end
        n_cmp++;
        if ({fq_req_vld, fq_req_pld} !== {1'b1, word_of(32'h200)}) begin
          n_err++;
          $display("FAIL bp_hold_word[%0d]: got %b %h expected 1 %h", i, fq_req_vld, fq_req_pld, word_of(32'h200));
        end
      end
      tick();
    end
    fq_req_rdy = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      got = (pushed.size() > i) ? pushed[i] : {33{1'bx}};
      n_cmp++;
      if (got !== {1'b0, word_of(32'h200 + 32'(4 * i))}) begin
        n_err++;
        $display("FAIL bp_drain_word[%0d]: got %h expected %h", i, got, {1'b0, word_of(32'h200 + 32'(4 * i))});
      end
    end
    drain();
  endtask

  task automatic test_kill_inflight();
    logic [32:0] got;
    issued.delete();
    pushed.delete();
    @(negedge clk);
    rsp_hold = 1'b1;
    tick();
    redirect_vld = 1'b1;
    redirect_pc  = 32'h0000_0300;
    fetch_en     = 1'b1;
    tick();
    redirect_vld = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_cmp++;
    if ({mem_req_vld, fq_req_vld} !== 2'b00) begin n_err++; $display("FAIL kill_full req/fq: got %b expected 00", {mem_req_vld, fq_req_vld}); end
    n_cmp++;
    if (issued.size() !== 2) begin n_err++; $display("FAIL kill_inflight_count: got %0d expected 2", issued.size()); end
    rsp_hold = 1'b0;
    tick();
    redirect_vld = 1'b1;
    redirect_pc  = 32'h0000_0400;
    pushed.delete();
    @(negedge clk);
    n_cmp++;
    if ({fq_clear, mem_req_vld, fq_req_vld} !== 3'b100) begin
      n_err++;
      $display("FAIL kill_redir_cycle clear/req/fq: got %b expected 100", {fq_clear, mem_req_vld, fq_req_vld});
    end
    tick();
    redirect_vld = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_req_vld, mem_req_addr} !== {1'b1, 32'h0000_0400}) begin
      n_err++;
      $display("FAIL kill_new_req: got %b %h expected 1 00000400", mem_req_vld, mem_req_addr);
    end
    repeat (8) tick();
    @(negedge clk);
    got = (pushed.size() > 0) ? pushed[0] : {33{1'bx}};
    n_cmp++;
    if (got !== {1'b0, word_of(32'h400)}) begin n_err++; $display("FAIL kill_first_word: got %h expected %h", got, {1'b0, word_of(32'h400)}); end
    got = (pushed.size() > 1) ? pushed[1] : {33{1'bx}};
    n_cmp++;
    if (got !== {1'b0, word_of(32'h404)}) begin n_err++; $display("FAIL kill_second_word: got %h expected %h", got, {1'b0, word_of(32'h404)}); end
    drain();
  endtask

  task automatic test_mem_stall();
    issued.delete();
    pushed.delete();
    tick();
    redirect_vld = 1'b1;
    redirect_pc  = 32'h0000_0500;
    fetch_en     = 1'b1;
    mem_req_rdy  = 1'b0;
    tick();
    redirect_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_req_vld, mem_req_addr} !== {1'b1, 32'h0000_0500}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got %b %h expected 1 00000500", i, mem_req_vld, mem_req_addr);
      end
      tick();
    end
    mem_req_rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_req_vld, mem_req_addr} !== {1'b1, 32'h0000_0500}) begin
      n_err++;
      $display("FAIL stall_release: got %b %h expected 1 00000500", mem_req_vld, mem_req_addr);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (mem_req_addr !== 32'h0000_0504) begin n_err++; $display("FAIL stall_advance: got %h expected 00000504", mem_req_addr); end
    n_cmp++;
    if (issued.size() !== 1) begin n_err++; $display("FAIL stall_handshakes: got %0d expected 1", issued.size()); end
  endtask

  task automatic test_reset_mid();
    logic [32:0] got;
    tick();
    fq_req_rdy = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({mem_req_vld, fq_req_vld, fq_clear, fq_mis_align} !== 4'b0000) begin
      n_err++;
      $display("FAIL midrst_flags: got %b expected 0000", {mem_req_vld, fq_req_vld, fq_clear, fq_mis_align});
    end
    n_cmp++;
    if ({mem_req_addr, fq_req_pld} !== 64'h0) begin
      n_err++;
      $display("FAIL midrst_addr_pld: got %h %h expected 00000000 00000000", mem_req_addr, fq_req_pld);
    end
    tick();
    rst        = 1'b0;
    fetch_en   = 1'b0;
    fq_req_rdy = 1'b1;
    pushed.delete();
    repeat (6) tick();
    @(negedge clk);
    n_cmp++;
    if ({fq_req_vld, 32'(pushed.size())} !== 33'h0) begin
      n_err++;
      $display("FAIL midrst_stale_push: got vld %b pushes %0d expected 0 0", fq_req_vld, pushed.size());
    end
    tick();
    fetch_en = 1'b1;
    issued.delete();
    pushed.delete();
    repeat (8) tick();
    @(negedge clk);
    n_cmp++;
    if (((issued.size() > 0) ? issued[0] : 32'hx) !== 32'h0) begin
      n_err++;
      $display("FAIL midrst_restart_addr: got %h expected 00000000", (issued.size() > 0) ? issued[0] : 32'hx);
    end
    for (int i = 0; i < 2; i++) begin
      got = (pushed.size() > i) ? pushed[i] : {33{1'bx}};
      n_cmp++;
      if (got !== {1'b0, word_of(32'(4 * i))}) begin
        n_err++;
        $display("FAIL midrst_restart_word[%0d]: got %h expected %h", i, got, {1'b0, word_of(32'(4 * i))});
      end
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_seq_stream();
    test_redirect_misalign();
    test_fq_backpressure();
    test_kill_inflight();
    test_mem_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
